// File: rtl/delay_path_arbiter_pkg.sv
// Shared constants and types for the delay path arbiter.
//   DV_WIDTH / DV_DEPTH : default data width and delay-path stage count
//   TAG_A / TAG_B       : owner encoding carried alongside each issued value
//   ptr_e               : round-robin priority pointer encoding
package delay_path_arbiter_pkg;

    localparam int DV_WIDTH = 34;
    localparam int DV_DEPTH = 5;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

endpackage

// File: rtl/delay_path_arbiter_if.sv
// Bundle of the arbiter's requester, delay-path and result signals.
//   slave  : the arbiter side (takes requests and path output, drives grants,
//            path input and result status)
//   master : the surrounding logic (requesters, the external delay path and
//            the consumer of the results)
interface delay_path_arbiter_if
    import delay_path_arbiter_pkg::*;
#(
    parameter int WIDTH = DV_WIDTH,
    parameter int DEPTH = DV_DEPTH
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             req_a;
    logic [WIDTH-1:0] din_a;
    logic             gnt_a;
    logic             req_b;
    logic [WIDTH-1:0] din_b;
    logic             gnt_b;
    logic             flush;
    logic [WIDTH-1:0] path_din;
    logic [WIDTH-1:0] path_dout;
    logic             out_valid;
    logic             out_tag;
    logic [WIDTH-1:0] dout;
    logic [CNT_W-1:0] in_flight;
    logic             busy;

    modport slave (
        input  req_a, din_a, req_b, din_b, flush, path_dout,
        output gnt_a, gnt_b, path_din, out_valid, out_tag, dout, in_flight, busy
    );

    modport master (
        output req_a, din_a, req_b, din_b, flush, path_dout,
        input  gnt_a, gnt_b, path_din, out_valid, out_tag, dout, in_flight, busy
    );

endinterface

// File: rtl/delay_tag_pipe.sv
// Valid/tag shift register that runs in lockstep with the external delay path.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : clears every valid bit at the next edge
//   in_vld, in_tag    : entry for the value issued this cycle
//   out_vld, out_tag  : entry leaving the last stage, aligned with path output
module delay_tag_pipe
    import delay_path_arbiter_pkg::*;
#(
    parameter int DEPTH = DV_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_vld,
    input  logic in_tag,
    output logic out_vld,
    output logic out_tag
);

    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] tag_p;

    // Stage 0 takes the new entry; stage i takes stage i-1. Tags keep moving
    // on flush, only the valid bits are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            tag_p <= {DEPTH{TAG_A}};
        end else begin
            vld_p[0] <= in_vld & ~flush;
            tag_p[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1] & ~flush;
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Output stage: last entry
    assign out_vld = vld_p[DEPTH-1];
    assign out_tag = tag_p[DEPTH-1];

endmodule

// File: rtl/delay_path_arbiter.sv
// Two-requester round-robin arbiter feeding a shared fixed-latency delay path.
// Tracks the owner and validity of every issued value so the path output can be
// labelled when it emerges DEPTH cycles later.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : delay_path_arbiter_if.slave
//               req_a/din_a/gnt_a, req_b/din_b/gnt_b : requesters
//               flush                               : discard in-flight values
//               path_din / path_dout                : external delay path
//               out_valid/out_tag/dout              : labelled path output
//               in_flight/busy                      : outstanding-value count
module delay_path_arbiter
    import delay_path_arbiter_pkg::*;
#(
    parameter int WIDTH = DV_WIDTH,
    parameter int DEPTH = DV_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    delay_path_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ptr_e             ptr_q;
    ptr_e             ptr_d;
    logic             gnt_a;
    logic             gnt_b;
    logic             grant;
    logic             pipe_vld;
    logic             pipe_tag;
    logic [CNT_W-1:0] cnt_q;

    // Priority pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Pointer moves to whichever requester lost; holds when nothing is granted
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_a) begin
            ptr_d = PTR_B;
        end else if (gnt_b) begin
            ptr_d = PTR_A;
        end
    end

    // Grants are purely combinational and deliberately not gated by reset
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!bus.flush) begin
            if (bus.req_a && (!bus.req_b || ptr_q == PTR_A)) begin
                gnt_a = 1'b1;
            end else if (bus.req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    assign grant = gnt_a | gnt_b;

    assign bus.gnt_a    = gnt_a;
    assign bus.gnt_b    = gnt_b;
    assign bus.path_din = gnt_a ? bus.din_a :
                          gnt_b ? bus.din_b : {WIDTH{1'b0}};

    delay_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .in_vld  (grant),
        .in_tag  (gnt_b ? TAG_B : TAG_A),
        .out_vld (pipe_vld),
        .out_tag (pipe_tag)
    );

    // Issue and retire in the same cycle cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else if (grant && !pipe_vld) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (!grant && pipe_vld) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bus.out_valid = pipe_vld;
    assign bus.out_tag   = pipe_tag;
    assign bus.dout      = bus.path_dout;
    assign bus.in_flight = cnt_q;
    assign bus.busy      = (cnt_q != '0);

endmodule

// File: doc/delay_path_arbiter.md
DELAY_PATH_ARBITER -- requirements
Module: delay_path_arbiter

Interface
REQ-001 Parameter WIDTH, default 34, data width of the shared delay value path.
REQ-002 Parameter DEPTH, default 5, register stages in the shared delay value path.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-high.
REQ-005 ReqA  input  1  requester A presents a value this cycle.
REQ-006 DinA  input  WIDTH  requester A value.
REQ-007 GntA  output  1  A's value is issued into the path this cycle.
REQ-008 ReqB  input  1  requester B presents a value this cycle.
REQ-009 DinB  input  WIDTH  requester B value.
REQ-010 GntB  output  1  B's value is issued into the path this cycle.
REQ-011 Flush  input  1  discard all in-flight values.
REQ-012 PathDin  output  WIDTH  drives the delay path input.
REQ-013 PathDout  input  WIDTH  delay path output.
REQ-014 OutValid  output  1  Dout carries an issued value this cycle.
REQ-015 OutTag  output  1  owner of Dout: 0 = A, 1 = B.
REQ-016 Dout  output  WIDTH  PathDout passed through unmodified.
REQ-017 InFlight  output  clog2(DEPTH+1)  count of issued values not yet delivered.
REQ-018 Busy  output  1  InFlight nonzero.

Function
REQ-019 GntA/GntB SHALL be combinational from ReqA, ReqB, Flush and the priority pointer; at most one asserted per cycle.
REQ-020 Only one requester active -> that requester granted.
REQ-021 Both active -> requester named by the priority pointer granted.
REQ-022 After any grant, the pointer SHALL move to the non-granted requester; with no grant, the pointer holds.
REQ-023 Flush high -> no grant that cycle, regardless of requests.
REQ-024 PathDin SHALL equal DinA on GntA, DinB on GntB, otherwise all zeros.
REQ-025 A DEPTH-entry valid/tag shift register SHALL advance every cycle, entering {grant, GntB}.
REQ-026 OutValid/OutTag SHALL be taken from the last shift-register entry, so a grant in cycle c gives OutValid in cycle c+DEPTH (5 by default), aligned with PathDout.
REQ-027 The path has no stall: OutValid is never held and there is no downstream backpressure.
REQ-028 InFlight update: +1 on grant only; -1 on OutValid only; unchanged when both occur or neither occurs.
REQ-029 Flush SHALL clear all shift-register valid bits and InFlight to 0 at the next edge.
REQ-030 OutValid SHALL be 0 for the DEPTH cycles after Flush, unless a new grant occurs.
REQ-031 Data already inside the path is not cleared; it is only marked invalid.
REQ-032 Flush and OutValid in the same cycle: the current OutValid still presents; InFlight goes to 0.
REQ-033 InFlight never exceeds DEPTH: at most one issue per cycle, and each issue retires after DEPTH cycles.
REQ-034 Back-to-back grants SHALL be accepted every cycle, giving full path throughput.

Reset
REQ-035 Reset asserted SHALL immediately clear shift-register valid and tag bits and InFlight to 0.
REQ-036 Reset asserted SHALL set the priority pointer to A.
REQ-037 Reset state outputs: OutValid=0, OutTag=0, Busy=0.
REQ-038 Reset does not gate GntA/GntB, PathDin or Dout: they follow REQ-019..REQ-024 and REQ-016 from live inputs.
REQ-039 Reset mid-operation SHALL discard all in-flight tracking; values leaving the path afterwards report OutValid=0.

Structure
REQ-040 A shared package SHALL hold DV_WIDTH=34, DV_DEPTH=5 and the tag encoding constants TAG_A=0, TAG_B=1.
REQ-041 The valid/tag shift register SHALL be one sub-module, delay_tag_pipe (DEPTH stages, 2 bits wide, async reset).
REQ-042 Arbitration, pointer and InFlight counter SHALL reside in delay_path_arbiter.
REQ-043 The delay path itself is instantiated outside this block.

Verification
REQ-044 Reset, then ReqA=1 with DinA=0x2_0000_0001 for 1 cycle -> GntA that cycle, PathDin=0x2_0000_0001; OutValid=1, OutTag=0 exactly 5 cycles later; InFlight 1 then 0.
REQ-045 ReqA=ReqB=1 continuously for 6 cycles -> grants A,B,A,B,A,B; OutTag sequence 0,1,0,1,0,1 starting 5 cycles after the first grant; InFlight peaks at 5.
REQ-046 ReqB only for 3 cycles, then both -> B,B,B, then A (pointer at A after B grants).
REQ-047 Issue 3 values, Flush one cycle later -> InFlight=0, OutValid stays 0 for the next 5 cycles; a request during Flush gets no grant.
REQ-048 Assert Reset asynchronously mid-cycle with 4 values in flight -> InFlight, OutValid and Busy drop to 0 before the next edge; the pointer returns to A.
REQ-049 No requests -> PathDin=0, Busy=0, no grants, for 10 cycles.
